// File: rtl/ipg_req_packer.sv
// Packs host read/write requests and write payload into 64-bit IPG request chunks
// through a one-deep output register that honours PHY back-pressure (tx_pause).
module ipg_req_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 40,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_LEN    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic                  tx_pause,
    output logic [DATA_WIDTH-1:0] ipg_req_chunk,
    output logic                  reqq_write,
    output logic                  busy,
    output logic                  err_len,
    output logic [15:0]           stat_req_sent
);

    typedef enum logic {IDLE, DATA} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

    state_t                state;
    logic                  out_valid;
    logic                  out_is_hdr;
    logic [7:0]            tag;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  slot_free;
    logic                  req_ok;
    logic                  req_fire;
    logic                  wd_fire;
    logic                  len_ok;
    logic [63:0]           header;

    // The slot can take a new chunk in the same cycle the old one drains.
    assign slot_free   = !out_valid || !tx_pause;
    assign req_ok      = (state == IDLE) && slot_free;
    assign req_ready   = rst_n && req_ok;
    assign wdata_ready = (state == DATA) && slot_free;
    assign reqq_write  = out_valid && !tx_pause;
    assign busy        = (state == DATA) || out_valid;

    assign req_fire = req_valid && req_ok;
    assign wd_fire  = wdata_valid && wdata_ready;
    assign len_ok   = (req_len != '0) && (req_len <= LEN_MAX);
    assign header   = {(req_is_write ? 8'h02 : 8'h01), tag, 8'(req_len), 40'(req_addr)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_is_hdr    <= 1'b0;
            tag           <= 8'd0;
            remaining     <= '0;
            stat_req_sent <= 16'd0;
            err_len       <= 1'b0;
            ipg_req_chunk <= '0;
        end else begin
            err_len <= req_fire && !len_ok;
            if (reqq_write) begin
                out_valid <= 1'b0;
                if (out_is_hdr)
                    stat_req_sent <= stat_req_sent + 16'd1;
            end
            // Illegal lengths are dropped without consuming a tag.
            if (req_fire && len_ok) begin
                out_valid     <= 1'b1;
                out_is_hdr    <= 1'b1;
                ipg_req_chunk <= DATA_WIDTH'(header);
                tag           <= tag + 8'd1;
                if (req_is_write) begin
                    remaining <= req_len;
                    state     <= DATA;
                end
            end
            if (wd_fire) begin
                out_valid     <= 1'b1;
                out_is_hdr    <= 1'b0;
                ipg_req_chunk <= wdata;
                remaining     <= remaining - LEN_ONE;
                if (remaining == LEN_ONE)
                    state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ipg_req_packer.sv
// Randomised bench for ipg_req_packer: a queue-based transaction model predicts every output each cycle.
module tb_ipg_req_packer;

    localparam int AW = 40;
    localparam int LW = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_is_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_valid = 1'b0;
    logic          tx_pause = 1'b0;
    logic          req_ready, wdata_ready, reqq_write, busy, err_len;
    logic [DW-1:0] ipg_req_chunk;
    logic [15:0]   stat_req_sent;

    ipg_req_packer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_write(req_is_write), .req_addr(req_addr), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .tx_pause(tx_pause), .ipg_req_chunk(ipg_req_chunk), .reqq_write(reqq_write),
        .busy(busy), .err_len(err_len), .stat_req_sent(stat_req_sent)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pause_pct = 0;
    bit force_pause = 1'b0;

    typedef struct { logic [63:0] d; bit hdr; } ent_t;
    ent_t        q[$];
    logic [7:0]  tag_m;
    logic [15:0] stat_m;
    int          rem_m, wr_cnt, err_cnt;
    bit          err_pend;
    logic [63:0] last_wr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: no handshake within cycle budget", nm);
    endtask

    // Back-pressure generator; changes after the drivers so both see a stable value at negedge.
    initial forever begin
        @(posedge clk);
        #2;
        tx_pause = force_pause || (pause_pct > 0 && $urandom_range(0, 99) < pause_pct);
    end

    // Model: the slot holds at most one queued chunk; a transfer is pending while payload remains.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_reqq_write", reqq_write, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_wdata_ready", wdata_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_len", err_len, 0);
            chk("rst_stat", stat_req_sent, 0);
            chk("rst_chunk", ipg_req_chunk, 0);
            q.delete();
            tag_m = 8'd0; stat_m = 16'd0; rem_m = 0; err_pend = 1'b0;
            wr_cnt = 0; err_cnt = 0;
        end else begin
            bit   free, e_rr, e_wr;
            ent_t e;
            free = (q.size() == 0) || !tx_pause;
            e_rr = (rem_m == 0) && free;
            e_wr = (rem_m != 0) && free;
            chk("req_ready", req_ready, e_rr);
            chk("wdata_ready", wdata_ready, e_wr);
            chk("reqq_write", reqq_write, (q.size() > 0) && !tx_pause);
            chk("busy", busy, (rem_m != 0) || (q.size() > 0));
            chk("err_len", err_len, err_pend);
            chk("stat_req_sent", stat_req_sent, stat_m);
            if (q.size() > 0) chk("chunk", ipg_req_chunk, q[0].d);
            if (q.size() > 0 && !tx_pause) begin
                e = q.pop_front();
                last_wr = e.d;
                wr_cnt++;
                if (e.hdr) stat_m = stat_m + 16'd1;
            end
            if (err_len) err_cnt++;
            err_pend = 1'b0;
            if (req_valid && e_rr) begin
                if (req_len != 0 && req_len <= 32) begin
                    e.d = {(req_is_write ? 8'h02 : 8'h01), tag_m, req_len, req_addr};
                    e.hdr = 1'b1;
                    q.push_back(e);
                    tag_m = tag_m + 8'd1;
                    if (req_is_write) rem_m = int'(req_len);
                end else begin
                    err_pend = 1'b1;
                end
            end else if (wdata_valid && e_wr) begin
                e.d = wdata;
                e.hdr = 1'b0;
                q.push_back(e);
                rem_m--;
            end
        end
    end

    task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        req_valid = 1'b1; req_is_write = w; req_addr = a; req_len = l;
        do begin @(negedge clk); n++; end while (!req_ready && n < 1000);
        if (!req_ready) timeout("req_handshake");
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = AW'({$urandom, $urandom}); req_len = LW'($urandom);
    endtask

    task automatic send_data(input logic [DW-1:0] d);
        int n = 0;
        wdata_valid = 1'b1; wdata = d;
        do begin @(negedge clk); n++; end while (!wdata_ready && n < 1000);
        if (!wdata_ready) timeout("wdata_handshake");
        @(posedge clk); #1;
        wdata_valid = 1'b0; wdata = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        req_valid = 1'b0; wdata_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] pb;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read: header presented the cycle after acceptance.
        send_req(1'b0, 40'h12_3456_7890, 8'd4);
        @(negedge clk);
        chk("read_write_strobe", reqq_write, 1);
        chk("read_header", ipg_req_chunk, 64'h0100_0412_3456_7890);
        @(negedge clk);
        chk("read_stat", stat_req_sent, 16'd1);
        @(posedge clk); #1;

        // Write of three payload chunks back to back.
        send_req(1'b1, 40'h100, 8'd3);
        send_data(64'hAAAA_0000_0000_000A);
        send_data(64'hBBBB_0000_0000_000B);
        send_data(64'hCCCC_0000_0000_000C);
        repeat (2) @(negedge clk);
        chk("write_last_chunk", last_wr, 64'hCCCC_0000_0000_000C);
        chk("write_busy_drop", busy, 0);
        chk("write_stat", stat_req_sent, 16'd2);
        @(posedge clk); #1;

        // Pause held for five cycles while payload B sits in the slot.
        pb = 64'hB0B0_1234_5678_9ABC;
        send_req(1'b1, 40'h200, 8'd3);
        send_data(64'hA0A0_0000_0000_0001);
        send_data(pb);
        force_pause = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("pause_no_write", reqq_write, 0);
            chk("pause_hold", ipg_req_chunk, pb);
        end
        force_pause = 1'b0;
        @(negedge clk);
        chk("pause_release_write", reqq_write, 1);
        chk("pause_release_chunk", ipg_req_chunk, pb);
        @(posedge clk); #1;
        send_data(64'hC0C0_0000_0000_0003);
        repeat (2) @(negedge clk);
        chk("pause_stat", stat_req_sent, 16'd3);
        @(posedge clk); #1;

        // Illegal lengths are dropped and do not consume tags.
        do_reset();
        send_req(1'b0, 40'h10, 8'd0);
        send_req(1'b0, 40'h20, 8'd33);
        repeat (2) @(negedge clk);
        chk("illegal_err_count", err_cnt, 2);
        chk("illegal_no_write", wr_cnt, 0);
        @(posedge clk); #1;
        send_req(1'b0, 40'h55, 8'd1);
        @(negedge clk);
        chk("illegal_next_hdr", ipg_req_chunk, 64'h0100_0100_0000_0055);
        @(posedge clk); #1;

        // Tag wrap over 257 reads.
        do_reset();
        for (int i = 0; i < 257; i++)
            send_req(1'b0, AW'({$urandom, $urandom}), LW'($urandom_range(1, 32)));
        repeat (2) @(negedge clk);
        chk("wrap_stat", stat_req_sent, 16'd257);
        chk("wrap_last_tag", last_wr[55:48], 8'h00);
        chk("wrap_writes", wr_cnt, 257);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a write.
        send_req(1'b1, 40'h300, 8'd3);
        send_data(64'h1111_2222_3333_4444);
        rst_n = 1'b0;
        #1;
        chk("async_chunk", ipg_req_chunk, 0);
        chk("async_busy", busy, 0);
        chk("async_strobe", reqq_write, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_stat", stat_req_sent, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_req(1'b0, 40'h77, 8'd2);
        @(negedge clk);
        chk("post_reset_hdr", ipg_req_chunk, 64'h0100_0200_0000_0077);
        @(posedge clk); #1;

        // Random mix under random back-pressure.
        pause_pct = 30;
        for (int t = 0; t < 300; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_req($urandom_range(0, 1) != 0, AW'({$urandom, $urandom}),
                         ($urandom_range(0, 1) != 0) ? 8'd0 : LW'($urandom_range(33, 255)));
            end else if (r < 5) begin
                send_req(1'b0, AW'({$urandom, $urandom}), LW'($urandom_range(1, 32)));
            end else begin
                int l;
                l = $urandom_range(1, 6);
                send_req(1'b1, AW'({$urandom, $urandom}), LW'(l));
                for (int k = 0; k < l; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_data({$urandom, $urandom});
                end
            end
        end
        pause_pct = 0;
        repeat (6) @(negedge clk);
        chk("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
